// File: rtl/cv32e40p_fault_pkg.sv
// Shared types and helpers for the TMR fault manager and its per-source run counters.
package cv32e40p_fault_pkg;

  typedef enum logic [1:0] {
    FM_IDLE      = 2'd0,
    FM_PENDING   = 2'd1,
    FM_PERMANENT = 2'd2
  } fault_state_e;

  // Priority encoder: index of the lowest set bit among the first n bits (0 if none).
  function automatic int unsigned lowest_idx(input logic [31:0] vec, input int unsigned n);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = n; i > 0; i--) begin
      if (vec[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cv32e40p_fault_persist.sv
// Per-source run counter of consecutive faulty cycles; flags a persistent mismatch.
module cv32e40p_fault_persist #(
  parameter int unsigned PERSIST_TH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic det_i,
  output logic hit_o
);

  localparam int unsigned RUN_W = $clog2(PERSIST_TH + 1);

  logic [RUN_W-1:0] run_q, run_d;

  always_comb begin
    run_d = '0;
    if (det_i) begin
      run_d = (run_q == RUN_W'(PERSIST_TH)) ? run_q : run_q + 1'b1;
    end
  end

  // Raised on the edge at which the run reaches the threshold, so the FSM locks in the same edge.
  assign hit_o = (run_d == RUN_W'(PERSIST_TH));

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/cv32e40p_fault_manager.sv
// Collects TMR voter mismatch flags: sticky status, event count, interrupt and recovery request.
module cv32e40p_fault_manager
  import cv32e40p_fault_pkg::*;
#(
  parameter  int unsigned NUM_SRC    = 4,
  parameter  int unsigned CNT_W      = 8,
  parameter  int unsigned PERSIST_TH = 4,
  localparam int unsigned ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] detected_i,
  input  logic [NUM_SRC-1:0] mask_i,
  input  logic               irq_ack_i,
  input  logic               clear_cnt_i,
  output logic               irq_o,
  output logic               recover_o,
  output logic               permanent_o,
  output logic [ID_W-1:0]    fault_src_o,
  output logic [NUM_SRC-1:0] fault_vec_o,
  output logic [CNT_W-1:0]   transient_cnt_o
);

  fault_state_e       state_q, state_d;
  logic [NUM_SRC-1:0] det_q, det_d;
  logic [NUM_SRC-1:0] det_prev_q, det_prev_d;
  logic [NUM_SRC-1:0] vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    src_q, src_d;
  logic               irq_q, irq_d;
  logic               rec_q, rec_d;
  logic               perm_q, perm_d;
  logic [NUM_SRC-1:0] hit;
  logic [31:0]        det_ext;
  logic               fault_event;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_persist
    cv32e40p_fault_persist #(
      .PERSIST_TH(PERSIST_TH)
    ) u_persist (
      .clk  (clk),
      .rst  (rst),
      .det_i(det_q[g]),
      .hit_o(hit[g])
    );
  end

  always_comb begin
    det_d      = detected_i & mask_i;
    det_prev_d = det_q;

    det_ext                = '0;
    det_ext[NUM_SRC-1:0]   = det_q;
    fault_event            = (|det_q) && !(|det_prev_q);

    vec_d = vec_q | det_q;
    cnt_d = cnt_q;
    if (fault_event && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    if (clear_cnt_i) begin
      vec_d = '0;
      cnt_d = '0;
    end

    state_d = state_q;
    irq_d   = irq_q;
    rec_d   = 1'b0;
    src_d   = src_q;
    perm_d  = perm_q;
    if (state_q == FM_PERMANENT) begin
      irq_d  = 1'b1;
      perm_d = 1'b1;
    end else if (|hit) begin
      state_d = FM_PERMANENT;
      irq_d   = 1'b1;
      perm_d  = 1'b1;
    end else if (state_q == FM_PENDING) begin
      if (irq_ack_i) begin
        state_d = FM_IDLE;
        irq_d   = 1'b0;
      end
    end else if (|det_q) begin
      state_d = FM_PENDING;
      irq_d   = 1'b1;
      rec_d   = 1'b1;
      src_d   = ID_W'(lowest_idx(det_ext, NUM_SRC));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FM_IDLE;
      det_q      <= '0;
      det_prev_q <= '0;
      vec_q      <= '0;
      cnt_q      <= '0;
      src_q      <= '0;
      irq_q      <= 1'b0;
      rec_q      <= 1'b0;
      perm_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      det_q      <= det_d;
      det_prev_q <= det_prev_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      irq_q      <= irq_d;
      rec_q      <= rec_d;
      perm_q     <= perm_d;
    end
  end

  assign irq_o           = irq_q;
  assign recover_o       = rec_q;
  assign permanent_o     = perm_q;
  assign fault_src_o     = src_q;
  assign fault_vec_o     = vec_q;
  assign transient_cnt_o = cnt_q;

endmodule
